pixel_gamma_pipe: RTL



---
 rtl/pixel_gamma_if.sv | 27 ++
 rtl/pixel_gamma_pipe.sv | 102 ++++++++++
 2 files changed

// File: rtl/pixel_gamma_if.sv
// Pixel path bundle between matrix controller / videoram / SPI write path and the gamma pipe.
// The slave modport is the gamma pipe; the master side is everything around it.
interface pixel_gamma_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [17:0]       mem_data;
  logic [7:0]        bright;
  logic              lut_we;
  logic [5:0]        lut_addr;
  logic [5:0]        lut_data;
  logic              lut_busy;
  logic [17:0]       pix_data;
  logic              pix_valid;

  modport master (
    output pix_addr, pix_req, mem_data, bright, lut_we, lut_addr, lut_data,
    input  mem_addr, lut_busy, pix_data, pix_valid
  );

  modport slave (
    input  pix_addr, pix_req, mem_data, bright, lut_we, lut_addr, lut_data,
    output mem_addr, lut_busy, pix_data, pix_valid
  );
endinterface

// File: rtl/pixel_gamma_pipe.sv
// RGB666 colour correction: videoram fetch, shared 64-entry gamma LUT, global brightness scale.
// Output appears MEM_LAT+3 cycles after pix_req; the LUT refills to identity after every reset.
module pixel_gamma_pipe #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 10
) (
  input  logic           clk,
  input  logic           rst,
  pixel_gamma_if.slave   bus
);

  typedef enum logic {INIT, RUN} state_t;

  state_t       state;
  logic [5:0]   cnt;
  logic [5:0]   lut [64];

  logic [MEM_LAT-1:0] req_dly;
  logic         vld_p0;
  logic         vld_p1;
  logic [5:0]   r_p0, g_p0, b_p0;
  logic [5:0]   r_p1, g_p1, b_p1;

  // Truncating scale by (bright+1)/256; the product never exceeds 14 bits.
  function automatic logic [5:0] scale_ch(input logic [5:0] v, input logic [7:0] b);
    logic [14:0] prod;
    prod = 15'(v) * 15'({1'b0, b} + 9'd1);
    return 6'(prod >> 8);
  endfunction

  // Entries the identity fill has not reached yet read as zero.
  function automatic logic [5:0] lut_rd(input logic [5:0] idx);
    if (state == INIT && idx >= cnt)
      return 6'd0;
    return lut[idx];
  endfunction

  assign bus.mem_addr = ADDR_W'(bus.pix_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      cnt          <= '0;
      bus.lut_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          lut[cnt] <= cnt;
          cnt      <= cnt + 6'd1;
          if (cnt == 6'd63) begin
            state        <= RUN;
            bus.lut_busy <= 1'b0;
          end
        end
        RUN: begin
          if (bus.lut_we)
            lut[bus.lut_addr] <= bus.lut_data;
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_dly       <= '0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      bus.pix_valid <= 1'b0;
    end else begin
      req_dly       <= MEM_LAT'({req_dly, bus.pix_req});
      vld_p0        <= req_dly[MEM_LAT-1];
      vld_p1        <= vld_p0;
      bus.pix_valid <= vld_p1;
    end
  end

  // Stage A: capture returned videoram word, split channels
  always_ff @(posedge clk) begin
    r_p0 <= bus.mem_data[17:12];
    g_p0 <= bus.mem_data[11:6];
    b_p0 <= bus.mem_data[5:0];
  end

  // Stage B: three parallel LUT reads; a same-edge write is not seen here
  always_ff @(posedge clk) begin
    r_p1 <= lut_rd(r_p0);
    g_p1 <= lut_rd(g_p0);
    b_p1 <= lut_rd(b_p0);
  end

  // Stage C: brightness scale, holds when no pixel arrives
  always_ff @(posedge clk) begin
    if (rst)
      bus.pix_data <= '0;
    else if (vld_p1)
      bus.pix_data <= {scale_ch(r_p1, bus.bright),
                       scale_ch(g_p1, bus.bright),
                       scale_ch(b_p1, bus.bright)};
  end

endmodule
